// File: rtl/fb_pixel_writer.sv
// Pixel writer: buffers accepted (x, y, colr) pixels in a small FIFO and
// issues them to the framebuffer as single-cycle-sustainable write requests.
// Latency: pixel accepted at edge N into an empty idle block -> fb_we high after edge N+1.
// Backpressure: oe drops when the FIFO holds DEPTH pixels; fb_we/addr/data hold until fb_ack.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   drawing, x, y, colr pixel offer from a line/span iterator (taken when drawing && oe)
//   oe                  high when a pixel may be accepted this cycle
//   fb_we, fb_addr,     framebuffer write request; fb_ack completes it
//   fb_data, fb_ack
//   busy                pixels buffered or a write outstanding
//   clip_cnt            number of discarded off-screen pixels
//
// Optional feature macro FB_PIXEL_WRITER_CLIP_EN: when defined, off-screen
// pixels are consumed but not written, and counted in clip_cnt. When not
// defined, every pixel is written with its address truncated and clip_cnt is 0.

module fb_pixel_writer #(
    parameter int CORDW = 9,
    parameter int COLRW = 4,
    parameter int H_RES = 320,
    parameter int V_RES = 180,
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              drawing,
    input  logic [CORDW-1:0]                  x,
    input  logic [CORDW-1:0]                  y,
    input  logic [COLRW-1:0]                  colr,
    output logic                              oe,
    output logic                              fb_we,
    output logic [$clog2(H_RES*V_RES)-1:0]    fb_addr,
    output logic [COLRW-1:0]                  fb_data,
    input  logic                              fb_ack,
    output logic                              busy,
    output logic [15:0]                       clip_cnt
);

    localparam int ADDRW = $clog2(H_RES*V_RES);
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [COLRW-1:0] colr;
    } pix_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    pix_t            mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;
    state_t          state;

    logic            accept;
    logic            clip;
    logic            push;
    logic            pop;
    pix_t            in_pix;
    pix_t            head;

    // oe depends only on the registered count, so the iterator can use it
    // to decide what to present without a loop through drawing.
    assign oe     = (count < CNTW'(DEPTH));
    assign accept = drawing && oe;

`ifdef FB_PIXEL_WRITER_CLIP_EN
    assign clip = (32'(x) >= 32'(H_RES)) || (32'(y) >= 32'(V_RES));
`else
    assign clip = 1'b0;
`endif

    assign push = accept && !clip;

    // Arithmetic done directly at ADDRW bits: the modular result equals the
    // full-width y*H_RES + x truncated to ADDRW.
    assign in_pix.addr = ADDRW'(y) * ADDRW'(H_RES) + ADDRW'(x);
    assign in_pix.colr = colr;

    assign head = mem[rd_ptr];

    // Load a new write whenever the FIFO has a pixel and the write slot is
    // free: either nothing is in flight, or the current write is being acked.
    // Only the registered count is used, so a pixel pushed on this edge is
    // seen one edge later.
    assign pop = (count != '0) && ((state == IDLE) || fb_ack);

    assign busy = (count != '0) || (state == WRITE);

    // Pixel storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= IDLE;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    // fb_ack has no effect here; nothing is outstanding.
                    if (pop) begin
                        fb_we   <= 1'b1;
                        fb_addr <= head.addr;
                        fb_data <= head.colr;
                        state   <= WRITE;
                    end else begin
                        fb_we <= 1'b0;
                    end
                end
                WRITE: begin
                    if (fb_ack) begin
                        if (pop) begin
                            // back-to-back: next pixel replaces the acked one
                            fb_we   <= 1'b1;
                            fb_addr <= head.addr;
                            fb_data <= head.colr;
                        end else begin
                            fb_we <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    fb_we <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FB_PIXEL_WRITER_CLIP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= '0;
        end else if (accept && clip && (clip_cnt != 16'hFFFF)) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end
`else
    assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: directed table, multi-cycle
// corner sequences and a randomized run against a queue-based reference.
// The reference tracks accepted pixels vs completed writes at transaction level.

module tb_fb_pixel_writer;

    localparam int CORDW = 9;
    localparam int COLRW = 4;
    localparam int H_RES = 320;
    localparam int V_RES = 180;
    localparam int DEPTH = 4;
    localparam int ADDRW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              drawing = 1'b0;
    logic [CORDW-1:0]  x = '0;
    logic [CORDW-1:0]  y = '0;
    logic [COLRW-1:0]  colr = '0;
    logic              oe;
    logic              fb_we;
    logic [ADDRW-1:0]  fb_addr;
    logic [COLRW-1:0]  fb_data;
    logic              fb_ack = 1'b0;
    logic              busy;
    logic [15:0]       clip_cnt;

    fb_pixel_writer #(
        .CORDW(CORDW), .COLRW(COLRW), .H_RES(H_RES), .V_RES(V_RES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drawing(drawing), .x(x), .y(y), .colr(colr),
        .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ack(fb_ack), .busy(busy), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [COLRW-1:0] data;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    int   outstanding = 0;   // accepted, unclipped pixels not yet acked
    int   clip_model = 0;
    int   cyc = 0;
    bit   run_inv = 1'b0;
    bit   hold_vld = 1'b0;
    wr_t  hold_wr;
    wr_t  exp_q[$];
    wr_t  got_q[$];
    int   got_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int model_addr(input int px, input int py);
        return (py * H_RES + px) % 65536;
    endfunction

    function automatic bit model_clip(input int px, input int py);
`ifdef FB_PIXEL_WRITER_CLIP_EN
        return (px >= H_RES) || (py >= V_RES);
`else
        return (px < 0) && (py < 0);
`endif
    endfunction

    // Transaction monitor: samples pre-edge values at each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (drawing && oe) begin
                if (model_clip(int'(x), int'(y))) begin
                    if (clip_model < 65535) clip_model++;
                end else begin
                    exp_q.push_back('{addr: 16'(model_addr(int'(x), int'(y))), data: colr});
                    outstanding++;
                end
            end
            if (fb_we && fb_ack) begin
                got_q.push_back('{addr: fb_addr, data: fb_data});
                got_cyc.push_back(cyc);
                outstanding--;
            end
            hold_vld = fb_we && !fb_ack;
            hold_wr  = '{addr: fb_addr, data: fb_data};
        end
    end

    // Per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && run_inv) begin
            chk("busy", 32'(busy), 32'(outstanding != 0));
            chk("oe", 32'(oe), 32'(outstanding <= DEPTH));
            chk("clip_cnt", 32'(clip_cnt), 32'(clip_model));
            if (hold_vld)
                chk("we_hold", 32'({fb_we, fb_addr, fb_data}), 32'({1'b1, hold_wr}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        outstanding = 0;
        clip_model  = 0;
        hold_vld    = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic apply_reset();
        drawing = 1'b0;
        fb_ack  = 1'b0;
        rst_n   = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Complete all outstanding writes, then compare write and accept streams.
    // base >= 0 additionally requires addresses base, base+1, ... on consecutive cycles.
    task automatic drain(input bit rnd_ack, input int base);
        int n;
        drawing = 1'b0;
        for (int c = 0; c < 400 && outstanding != 0; c++) begin
            fb_ack = rnd_ack ? 1'($urandom % 2) : 1'b1;
            tick();
        end
        fb_ack = 1'b0;
        chk("drain_timeout", 32'(outstanding), 32'd0);
        chk("wr_count", 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
            chk("wr_data", 32'(got_q[i].data), 32'(exp_q[i].data));
            if (base >= 0) begin
                chk("b2b_addr", 32'(got_q[i].addr), 32'(base + i));
                chk("b2b_cycle", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
            end
        end
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    typedef struct {
        int x;
        int y;
        int c;
        int exp_addr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int accepted;
        bit acc;

        tbl[0] = '{5, 2, 7, 645};
        tbl[1] = '{0, 0, 0, 0};
        tbl[2] = '{319, 179, 15, 57599};
        tbl[3] = '{0, 1, 3, 320};
`ifdef FB_PIXEL_WRITER_CLIP_EN
        tbl[4] = '{200, 150, 12, 48200};
`else
        tbl[4] = '{511, 511, 9, 32959};
`endif

        // Reset state, checked while reset is held.
        rst_n = 1'b0;
        #3;
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oe", 32'(oe), 32'd1);
        chk("rst_clip", 32'(clip_cnt), 32'd0);
        apply_reset();
        run_inv = 1'b1;

        // Single pixels with immediate ack: latency, one-cycle fb_we, address.
        for (int i = 0; i < 5; i++) begin
            x = 9'(tbl[i].x); y = 9'(tbl[i].y); colr = 4'(tbl[i].c);
            drawing = 1'b1; fb_ack = 1'b1;
            tick();
            drawing = 1'b0;
            chk("lat_early", 32'(fb_we), 32'd0);
            tick();
            chk("lat_we", 32'(fb_we), 32'd1);
            chk("single_addr", 32'(fb_addr), 32'(tbl[i].exp_addr));
            chk("single_data", 32'(fb_data), 32'(tbl[i].c));
            tick();
            chk("we_one_cycle", 32'(fb_we), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
        end
        drain(1'b0, -1);

        // Stalled framebuffer: FIFO fills, oe drops, write stays at first pixel.
        fb_ack = 1'b0; y = 9'd0; x = 9'd10; colr = 4'd10; drawing = 1'b1;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            acc = oe;
            tick();
            if (acc) begin
                accepted++;
                x = x + 9'd1;
                colr = colr + 4'd1;
            end
        end
        chk("stall_accepted", 32'(accepted), 32'(DEPTH + 1));
        chk("stall_we", 32'(fb_we), 32'd1);
        chk("stall_addr", 32'(fb_addr), 32'd10);
        chk("stall_oe", 32'(oe), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        drain(1'b0, 10);

        // Always-acked span: one write per cycle, oe never drops.
        fb_ack = 1'b1; y = 9'd1;
        for (int i = 0; i < 8; i++) begin
            x = 9'(i); colr = 4'(i + 1); drawing = 1'b1;
            chk("span_oe", 32'(oe), 32'd1);
            tick();
        end
        drawing = 1'b0;
        drain(1'b0, 320);

        // Randomized pixels with 50% ack.
        accepted = 0;
        for (int c = 0; c < 5000 && accepted < 100; c++) begin
            drawing = ($urandom % 4) != 0;
            x = 9'($urandom_range(0, 339));
            y = 9'($urandom_range(0, 189));
            colr = 4'($urandom);
            fb_ack = 1'($urandom % 2);
            acc = drawing && oe;
            tick();
            if (acc) accepted++;
        end
        chk("rand_accepted", 32'(accepted), 32'd100);
        drain(1'b1, -1);

        // Reset mid-burst with pixels buffered: immediate clear, no stale writes.
        fb_ack = 1'b0; y = 9'd3;
        for (int i = 0; i < 4; i++) begin
            x = 9'(20 + i); colr = 4'(i + 2); drawing = 1'b1;
            chk("pre_rst_oe", 32'(oe), 32'd1);
            tick();
        end
        drawing = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        chk("arst_we", 32'(fb_we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_oe", 32'(oe), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fb_ack = 1'b1; y = 9'd4;
        for (int i = 0; i < 2; i++) begin
            x = 9'(30 + i); colr = 4'(i + 8); drawing = 1'b1;
            tick();
        end
        drawing = 1'b0;
        drain(1'b0, -1);

        // Off-screen pixels; oe must stay high throughout.
        apply_reset();
        fb_ack = 1'b1;
        x = 9'd320; y = 9'd0; colr = 4'd5; drawing = 1'b1;
        chk("clip_oe0", 32'(oe), 32'd1);
        tick();
        x = 9'd0; y = 9'd180; colr = 4'd6;
        chk("clip_oe1", 32'(oe), 32'd1);
        tick();
        x = 9'd1; y = 9'd1; colr = 4'd7;
        chk("clip_oe2", 32'(oe), 32'd1);
        tick();
        drawing = 1'b0;
        repeat (4) tick();
`ifdef FB_PIXEL_WRITER_CLIP_EN
        chk("clip_count", 32'(clip_cnt), 32'd2);
        chk("clip_writes", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("clip_addr", 32'(got_q[0].addr), 32'd321);
`else
        chk("clip_count", 32'(clip_cnt), 32'd0);
        chk("clip_writes", 32'(got_q.size()), 32'd3);
        if (got_q.size() > 2) chk("clip_addr", 32'(got_q[2].addr), 32'd321);
`endif
        drain(1'b0, -1);

        run_inv = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
